y86_dmem_responder: RTL and testbench
=====================================

# y86_dmem_responder

Memory-side responder for the Y86-64 data-memory interface. It accepts one 8-byte read or write request at a time from the memory-stage request generator (rEn/wEn, address, data), and services it over a byte-serial little-endian array. It returns valM with a done/error response and sits between the memory stage and the byte-addressed data store. It replaces single-cycle array access with a valid/ready handshake so the pipeline can stall on memory.

## Interface
- DEPTH, 65536: bytes of storage; legal addresses 0..DEPTH-1.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_rEn  in  1  read request.
- req_wEn  in  1  write request.
- req_addr  in  64  byte address of lowest byte.
- req_wdata  in  64  write data, little-endian.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts response.
- resp_valM  out  64  read data; 0 for writes and errors.
- resp_err  out  1  dmem_err for this request.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture rEn, wEn, addr, and wdata.
  - If the request is in error, go to RESP with resp_err=1 and resp_valM=0. No array access.
  - Otherwise go to ACCESS with byte counter k=0.
- Error conditions:
  - rEn&&wEn both set.
  - addr > DEPTH-8. This is a 64-bit compare with no wrap, so addr=0xFFFF_FFFF_FFFF_FFF9 is an error.
- Neither rEn nor wEn set (nop request): accepted, goes straight to RESP with err=0 and valM=0.
- ACCESS: one byte per cycle, k=0..7.
  - Write: mem[addr+k] <= wdata[8k+7:8k].
  - Read: rdata[8k+7:8k] <= mem[addr+k].
  - After k=7, go to RESP with err=0. valM = assembled rdata for reads, 0 for writes.
- RESP: resp_valid=1, and resp_valM/resp_err are stable. On resp_ready, go to IDLE.
- Inputs are sampled only at acceptance. Changes to req_* afterwards are ignored.
- req_valid outside IDLE is ignored (not accepted).
- Reset: state=IDLE, counter=0, resp_valid=0, resp_valM=0, resp_err=0, and req_ready=0 during the reset cycle.
  - Array contents are not cleared.
- Reset mid-ACCESS: abort with no response. Bytes already written stay written.

## Timing
- Request accepted at edge T (in IDLE).
- Normal access: bytes k=0..7 handled at edges T+1..T+8. resp_valid is high from the cycle after T+8 until the edge where resp_ready=1.
- Total latency from acceptance edge to resp_valid: 9 cycles.
- Error or nop: resp_valid high the cycle after T (1-cycle latency).
- resp_ready sampled high in RESP: return to IDLE on that edge. req_ready is high the following cycle, giving a 1-cycle bubble between transactions.
- resp_ready held high continuously: resp_valid lasts exactly one cycle.
- Read after write to an overlapping address returns the new data, because the write completes before its response.

## Test plan
- Write then read: write addr=0x100, wdata=0x0123456789ABCDEF, then read 0x100.
  - Response 9 cycles after acceptance.
  - resp_valM=0x0123456789ABCDEF, err=0.
  - mem[0x100]=0xEF and mem[0x107]=0x01.
- Upper bound: read addr=DEPTH-8 gives err=0. Read addr=DEPTH-7 gives err=1, valM=0, resp 1 cycle after accept, and no array access.
- Huge address: addr=0xFFFF_FFFF_FFFF_FFFC gives err=1 (no wrap). Both rEn and wEn set gives err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid, valM, and err stay stable.
  - req_ready=0 throughout, and a concurrent req_valid is not accepted.
  - Accepted only after the return to IDLE.
- Reset mid-write: assert rst after k=3 of a write of 0xFFFF_FFFF_FFFF_FFFF to 0x200 (previously 0).
  - No response.
  - mem[0x200..0x203]=0xFF and mem[0x204..0x207]=0x00.
  - req_ready=1 the cycle after rst deasserts.
- Back-to-back: 3 reads with resp_ready tied high. Each response is 1-cycle wide, and requests are accepted every 10 cycles.

Source files
------------

// File: rtl/y86_dmem_responder_if.sv
// Request/response bus between the Y86-64 memory stage and the data-memory
// responder.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// resp_valid and resp_ready are both high. A valid is held, with its payload
// stable, until it transfers.
interface y86_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rEn;
    logic        req_wEn;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_valM;
    logic        resp_err;

    // Memory stage side: issues requests, consumes responses.
    modport master (
        output req_valid, req_rEn, req_wEn, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_valM, resp_err
    );

    // Responder side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_rEn, req_wEn, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_valM, resp_err
    );
endinterface

// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder. Accepts one 8-byte request at a time and
// services it over a byte-wide little-endian array, one byte per cycle.
// Bad requests (both enables set, or any byte past the end of storage) and
// nop requests are answered without touching the array.
module y86_dmem_responder #(
    parameter int DEPTH = 65536
) (
    input  logic                       clk,
    input  logic                       rst,
    y86_dmem_responder_if.slave        bus,
    output logic [1:0]                 dbgState
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t         state;
    state_t         stateNext;
    logic [2:0]     k;
    logic           rEnQ;
    logic           wEnQ;
    logic [AW-1:0]  addrQ;
    logic [63:0]    wdataQ;
    logic [55:0]    rdata;
    logic [63:0]    valMQ;
    logic           errQ;
    logic [7:0]     mem [DEPTH];

    logic           reqErr;
    logic           reqNop;
    logic [AW-1:0]  byteAddr;
    logic [7:0]     rdByte;

    // The address compare is a full 64-bit compare so huge addresses never wrap.
    assign reqErr   = (bus.req_rEn && bus.req_wEn) || (bus.req_addr > 64'(DEPTH - 8));
    assign reqNop   = !bus.req_rEn && !bus.req_wEn;
    assign byteAddr = addrQ + {{(AW-3){1'b0}}, k};
    assign rdByte   = mem[byteAddr];

    assign bus.resp_valM = valMQ;
    assign bus.resp_err  = errQ;
    assign dbgState      = state;

    // Next-state and handshake outputs; req_ready is forced low while in reset.
    always_comb begin
        stateNext      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) begin
                    stateNext = (reqErr || reqNop) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (k == 3'd7) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request capture, byte counter, read assembly and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k     <= 3'd0;
            valMQ <= 64'd0;
            errQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        rEnQ   <= bus.req_rEn;
                        wEnQ   <= bus.req_wEn;
                        addrQ  <= bus.req_addr[AW-1:0];
                        wdataQ <= bus.req_wdata;
                        k      <= 3'd0;
                        if (reqErr || reqNop) begin
                            errQ  <= reqErr;
                            valMQ <= 64'd0;
                        end
                    end
                end
                ACCESS: begin
                    k <= k + 3'd1;
                    // Bytes shift in from the top; after seven shifts byte 0 sits at [7:0].
                    rdata <= {rdByte, rdata[55:8]};
                    if (k == 3'd7) begin
                        errQ  <= 1'b0;
                        valMQ <= rEnQ ? {rdByte, rdata} : 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte array write port; a reset edge never commits a byte.
    always_ff @(posedge clk) begin
        if (!rst && state == ACCESS && wEnQ) begin
            mem[byteAddr] <= wdataQ[{k, 3'b000} +: 8];
        end
    end
endmodule

// File: tb/tb_y86_dmem_responder.sv
// Bench for y86_dmem_responder: directed boundary cases plus randomized
// traffic checked against a byte-array reference model.
module tb_y86_dmem_responder;
    localparam int DEPTH = 65536;
    localparam int NORMAL_LAT = 8;  // rising edges after the accepting edge until resp_valid is seen
    localparam int SHORT_LAT  = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbgState;

    y86_dmem_responder_if bus();

    y86_dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0]  refMem [int];
    logic [63:0] exp_q[$];

    task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] modelRead(input logic [63:0] a);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (refMem.exists(int'(a) + i)) v[8*i +: 8] = refMem[int'(a) + i];
        end
        return v;
    endfunction

    // Reference behaviour of one request: response value, error flag, latency.
    task automatic modelApply(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                              output logic [63:0] expV, output logic expE, output int expLat);
        expV = 64'd0;
        expE = 1'b0;
        expLat = SHORT_LAT;
        if ((r && w) || (a > 64'(DEPTH) - 64'd8)) begin
            expE = 1'b1;
        end else if (w) begin
            for (int i = 0; i < 8; i++) refMem[int'(a) + i] = d[8*i +: 8];
            expLat = NORMAL_LAT;
        end else if (r) begin
            expV = modelRead(a);
            expLat = NORMAL_LAT;
        end
    endtask

    // Drive one request, check latency/response, hold backpressure for 'stall' cycles.
    task automatic runReq(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d,
                          input int stall, input string tag);
        logic [63:0] expV;
        logic        expE;
        int          expLat;
        int          lat;
        int          budget;
        modelApply(r, w, a, d, expV, expE, expLat);
        exp_q.push_back(expV);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rEn   = r;
        bus.req_wEn   = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        budget = 0;
        while (!bus.req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkVal({tag, "/accept"}, 64'(bus.req_ready), 64'd1);
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        // Scramble request fields: the responder must have captured them already.
        bus.req_valid = 1'b0;
        bus.req_rEn   = 1'($urandom);
        bus.req_wEn   = 1'($urandom);
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.resp_valid && lat < 30);
        checkVal({tag, "/lat"}, 64'(lat), 64'(expLat));
        checkVal({tag, "/valM"}, bus.resp_valM, exp_q.pop_front());
        checkVal({tag, "/err"}, 64'(bus.resp_err), 64'(expE));
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkVal({tag, "/holdValid"}, 64'(bus.resp_valid), 64'd1);
            checkVal({tag, "/holdValM"}, bus.resp_valM, expV);
            checkVal({tag, "/holdErr"}, 64'(bus.resp_err), 64'(expE));
            checkVal({tag, "/holdReqReady"}, 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        checkVal({tag, "/respDone"}, 64'(bus.resp_valid), 64'd0);
        checkVal({tag, "/backIdle"}, 64'(bus.req_ready), 64'd1);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          accCyc [3];
        int          nAcc;
        int          nResp;
        int          run;
        int          maxRun;
        int          stray;
        logic [63:0] b2bExp [3];
        logic [63:0] a;
        logic [63:0] d;
        int          sel;

        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_rEn    = 1'b0;
        bus.req_wEn    = 1'b0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst/reqReady", 64'(bus.req_ready), 64'd0);
        checkVal("rst/respValid", 64'(bus.resp_valid), 64'd0);
        checkVal("rst/valM", bus.resp_valM, 64'd0);
        checkVal("rst/err", 64'(bus.resp_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("rst/readyAfter", 64'(bus.req_ready), 64'd1);

        // Write then read, plus an unaligned read spanning two words.
        runReq(1'b0, 1'b1, 64'h100, 64'h0123456789ABCDEF, 0, "w100");
        runReq(1'b1, 1'b0, 64'h100, 64'd0, 0, "r100");
        runReq(1'b0, 1'b1, 64'h108, 64'h1122334455667788, 0, "w108");
        runReq(1'b1, 1'b0, 64'h107, 64'd0, 0, "r107");

        // Upper-bound, huge-address, conflicting-enable and nop requests.
        runReq(1'b0, 1'b1, 64'(DEPTH - 8), 64'hCAFEF00DDEADBEEF, 0, "wTop");
        runReq(1'b1, 1'b0, 64'(DEPTH - 8), 64'd0, 0, "rTop");
        runReq(1'b1, 1'b0, 64'(DEPTH - 7), 64'd0, 0, "rTopPlus1");
        runReq(1'b0, 1'b1, 64'(DEPTH - 7), 64'hFFFFFFFFFFFFFFFF, 0, "wTopPlus1");
        runReq(1'b1, 1'b0, 64'(DEPTH - 8), 64'd0, 0, "rTopAgain");
        runReq(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0, "rHuge");
        runReq(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h5555, 0, "wHuge");
        runReq(1'b1, 1'b1, 64'h100, 64'hAAAAAAAAAAAAAAAA, 0, "both");
        runReq(1'b0, 1'b0, 64'h100, 64'hAAAAAAAAAAAAAAAA, 0, "nop");
        runReq(1'b1, 1'b0, 64'h100, 64'd0, 5, "backpressure");

        // Reset during a write: only bytes k=0..3 are committed.
        runReq(1'b0, 1'b1, 64'h200, 64'd0, 0, "clr200");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rEn   = 1'b0;
        bus.req_wEn   = 1'b1;
        bus.req_addr  = 64'h200;
        bus.req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        checkVal("rstMid/accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) refMem[32'h200 + i] = 8'hFF;
        @(negedge clk);
        checkVal("rstMid/reqReadyInRst", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkVal("rstMid/reqReadyAfter", 64'(bus.req_ready), 64'd1);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.resp_valid) stray++;
            @(negedge clk);
        end
        checkVal("rstMid/noResp", 64'(stray), 64'd0);
        runReq(1'b1, 1'b0, 64'h200, 64'd0, 0, "rstMid/read200");

        // Fill the random-traffic window so every read has a known value.
        for (int i = 0; i < 33; i++) begin
            runReq(1'b0, 1'b1, 64'h1000 + 64'(8 * i), {$urandom, $urandom}, 0, "fill");
        end

        // Back-to-back reads with resp_ready tied high.
        for (int i = 0; i < 3; i++) b2bExp[i] = modelRead(64'h1000 + 64'(8 * i));
        @(negedge clk);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_rEn    = 1'b1;
        bus.req_wEn    = 1'b0;
        bus.req_addr   = 64'h1000;
        nAcc = 0;
        nResp = 0;
        run = 0;
        maxRun = 0;
        for (int c = 0; c < 40; c++) begin
            logic acc;
            acc = bus.req_valid && bus.req_ready;
            if (acc && nAcc < 3) begin
                accCyc[nAcc] = c;
                nAcc++;
            end
            if (bus.resp_valid) begin
                if (nResp < 3) checkVal("b2b/valM", bus.resp_valM, b2bExp[nResp]);
                nResp++;
                run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (nAcc < 3) bus.req_addr = 64'h1000 + 64'(8 * nAcc);
                else bus.req_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        checkVal("b2b/accepts", 64'(nAcc), 64'd3);
        checkVal("b2b/responses", 64'(nResp), 64'd3);
        checkVal("b2b/respWidth", 64'(maxRun), 64'd1);
        if (nAcc == 3) begin
            checkVal("b2b/gap01", 64'(accCyc[1] - accCyc[0]), 64'd10);
            checkVal("b2b/gap12", 64'(accCyc[2] - accCyc[1]), 64'd10);
        end

        // Randomized traffic over the filled window and the top of memory.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 5) == 0) a = 64'(DEPTH - 8) + 64'($urandom_range(0, 16));
            else a = 64'h1000 + 64'($urandom_range(0, 248));
            d = {$urandom, $urandom};
            case (sel)
                0:       runReq(1'b0, 1'b0, a, d, $urandom_range(0, 3), "rndNop");
                1:       runReq(1'b1, 1'b1, a, d, $urandom_range(0, 3), "rndBoth");
                2, 3, 4, 5: runReq(1'b1, 1'b0, a, d, $urandom_range(0, 3), "rndRead");
                default: runReq(1'b0, 1'b1, a, d, $urandom_range(0, 3), "rndWrite");
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
